ad7606_emu: RTL and testbench



---
 rtl/ad7606_pkg.sv | 23 ++
 rtl/ad7606_emu_regfile.sv | 92 +++++++++
 rtl/ad7606_emu.sv | 192 +++++++++++++++++++
 tb/tb_ad7606_emu.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ad7606_pkg.sv
// Shared definitions for the AD7606 responder emulator: state encoding,
// channel count, default timing and the sample type.
// The sample width comes from AD_DATA_NBIT (16 when the build does not set it).
// Build option AD7606_EMU_RAMP_EN (see ad7606_emu) replaces ch_in with a ramp.
`timescale 1ns/1ps
`ifndef AD_DATA_NBIT
`define AD_DATA_NBIT 16
`endif

package ad7606_pkg;

    localparam int NUM_CH       = 8;
    localparam int DEF_BUSY_DLY = 3;
    localparam int DEF_CONV_CYC = 200;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DLY   = 2'd1;
    localparam logic [1:0] ST_CONV  = 2'd2;
    localparam logic [1:0] ST_READY = 2'd3;

    typedef logic [`AD_DATA_NBIT-1:0] sample_t;

endpackage

// File: rtl/ad7606_emu_regfile.sv
// Track/hold register, 8-entry output register file and the registered
// read-pointer mux that drives the parallel data bus.
`timescale 1ns/1ps
`ifndef AD_DATA_NBIT
`define AD_DATA_NBIT 16
`endif

module ad7606_emu_regfile
    import ad7606_pkg::*;
#(
    parameter int DATA_W = `AD_DATA_NBIT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     latch,
    input  logic                     commit,
    input  logic                     out_en,
    input  logic [2:0]               ptr,
    input  logic [NUM_CH*DATA_W-1:0] sample_in,
    output logic [DATA_W-1:0]        ad_data,
    output logic                     first_data
);

    logic [NUM_CH*DATA_W-1:0] regs_flat;
    logic [DATA_W-1:0]        rd_word;
    logic [DATA_W-1:0]        ad_data_q, ad_data_d;
    logic                     first_data_q, first_data_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DATA_W-1:0] hold_q, hold_d;
            logic [DATA_W-1:0] regs_q, regs_d;

            // Hold captures the sample set at conversion start; regs take it at conversion end
            always_comb begin
                hold_d = hold_q;
                regs_d = regs_q;
                if (clr) begin
                    hold_d = '0;
                    regs_d = '0;
                end else begin
                    if (latch)
                        hold_d = sample_in[gi*DATA_W +: DATA_W];
                    if (commit)
                        regs_d = hold_q;
                end
            end

            // Per-channel storage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_q <= '0;
                    regs_q <= '0;
                end else begin
                    hold_q <= hold_d;
                    regs_q <= regs_d;
                end
            end

            assign regs_flat[gi*DATA_W +: DATA_W] = regs_q;
        end
    endgenerate

    assign rd_word = regs_flat[32'(ptr)*DATA_W +: DATA_W];

    // Bus is driven only while chip select is active
    always_comb begin
        ad_data_d    = '0;
        first_data_d = 1'b0;
        if (out_en) begin
            ad_data_d    = rd_word;
            first_data_d = (ptr == 3'd0);
        end
    end

    // Output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ad_data_q    <= '0;
            first_data_q <= 1'b0;
        end else begin
            ad_data_q    <= ad_data_d;
            first_data_q <= first_data_d;
        end
    end

    assign ad_data    = ad_data_q;
    assign first_data = first_data_q;

endmodule

// File: rtl/ad7606_emu.sv
// AD7606 parallel-interface ADC emulator (responder side). A convst rising
// edge starts a conversion: BUSY after BUSY_DLY cycles, high for CONV_CYC
// cycles, then eight results are served through cs/rd reads.
// Define AD7606_EMU_RAMP_EN to source samples from an internal ramp counter
// instead of ch_in.
`timescale 1ns/1ps
`ifndef AD_DATA_NBIT
`define AD_DATA_NBIT 16
`endif

module ad7606_emu
    import ad7606_pkg::*;
#(
    parameter int DATA_W   = `AD_DATA_NBIT,
    parameter int BUSY_DLY = DEF_BUSY_DLY,
    parameter int CONV_CYC = DEF_CONV_CYC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ad_reset,
    input  logic                     ad_convstab,
    input  logic                     ad_cs,
    input  logic                     ad_rd,
    input  logic [NUM_CH*DATA_W-1:0] ch_in,
    input  logic [2:0]               ad_os,
    output logic [DATA_W-1:0]        ad_data,
    output logic                     ad_busy,
    output logic                     first_data
);

    localparam int CNT_MAX = (BUSY_DLY > CONV_CYC) ? BUSY_DLY : CONV_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic             cs_q, cs_d, rd_q, rd_d, cv_q, cv_d;
    logic             rd_prev_q, rd_prev_d, cv_prev_q, cv_prev_d;
    logic [2:0]       os_q, os_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [2:0]       ptr_q, ptr_d;
    logic             cv_edge, rd_edge, latch, commit;
    logic [NUM_CH*DATA_W-1:0] sample_set;

    // Input stage: one register per control pin plus the previous value for edge detection
    always_comb begin
        cs_d      = ad_cs;
        rd_d      = ad_rd;
        cv_d      = ad_convstab;
        os_d      = ad_os;
        rd_prev_d = rd_q;
        cv_prev_d = cv_q;
    end

    // Input registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q      <= 1'b1;
            rd_q      <= 1'b1;
            cv_q      <= 1'b0;
            os_q      <= 3'd0;
            rd_prev_q <= 1'b1;
            cv_prev_q <= 1'b0;
        end else begin
            cs_q      <= cs_d;
            rd_q      <= rd_d;
            cv_q      <= cv_d;
            os_q      <= os_d;
            rd_prev_q <= rd_prev_d;
            cv_prev_q <= cv_prev_d;
        end
    end

    assign cv_edge = cv_q & ~cv_prev_q;
    assign rd_edge = rd_q & ~rd_prev_q;

`ifdef AD7606_EMU_RAMP_EN
    logic [15:0] ramp_q, ramp_d;

    // Ramp advances once per completed conversion
    always_comb begin
        ramp_d = ramp_q;
        if (ad_reset)
            ramp_d = 16'd0;
        else if (commit)
            ramp_d = ramp_q + 16'd1;
    end

    // Ramp counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ramp_q <= 16'd0;
        else
            ramp_q <= ramp_d;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ramp
            assign sample_set[gi*DATA_W +: DATA_W] = DATA_W'(ramp_q + 16'(gi * 4096));
        end
    endgenerate
`else
    assign sample_set = ch_in;
`endif

    // Conversion sequencer and read pointer; controller reset overrides everything
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        latch   = 1'b0;
        commit  = 1'b0;

        // Reads are served in every state except IDLE, including mid-conversion
        if (rd_edge && !cs_q && state_q != ST_IDLE)
            ptr_d = ptr_q + 3'd1;

        case (state_q)
            ST_IDLE, ST_READY: begin
                if (cv_edge) begin
                    latch   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_DLY;
                end
            end
            ST_DLY: begin
                if (cnt_q == CNT_W'(BUSY_DLY - 1)) begin
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_CONV;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CONV: begin
                if (cnt_q == CNT_W'(CONV_CYC - 1)) begin
                    busy_d  = 1'b0;
                    commit  = 1'b1;
                    ptr_d   = 3'd0;   // fresh results always start at channel 1
                    cnt_d   = '0;
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (ad_reset) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            ptr_d   = 3'd0;
            latch   = 1'b0;
            commit  = 1'b0;
        end
    end

    // Sequencer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
        end
    end

    assign ad_busy = busy_q;

    ad7606_emu_regfile #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (ad_reset),
        .latch      (latch),
        .commit     (commit),
        .out_en     (~cs_q),
        .ptr        (ptr_q),
        .sample_in  (sample_set),
        .ad_data    (ad_data),
        .first_data (first_data)
    );

endmodule

// File: tb/tb_ad7606_emu.sv
// Self-checking bench for ad7606_emu: directed sequence with randomized
// channel data, checked against a channel-level model of the ADC.
`timescale 1ns/1ps

module tb_ad7606_emu;

    localparam int DW   = 16;
    localparam int BDLY = 3;
    localparam int CCYC = 200;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ad_reset = 1'b0;
    logic            ad_convstab = 1'b0;
    logic            ad_cs = 1'b1;
    logic            ad_rd = 1'b1;
    logic [8*DW-1:0] ch_in = '0;
    logic [2:0]      ad_os = 3'd0;
    logic [DW-1:0]   ad_data;
    logic            ad_busy;
    logic            first_data;

    int checks = 0;
    int failures = 0;

    // Channel-level model: results visible to reads, held samples, pointer
    logic [DW-1:0] m_regs [8];
    logic [DW-1:0] m_hold [8];
    int            m_ptr;
    bit            m_idle;
    int            m_ramp;

    // Busy pulse monitor
    int run_len = 0;
    int last_width = 0;
    int pulses = 0;

    always #10 clk = ~clk;

    ad7606_emu #(
        .DATA_W   (DW),
        .BUSY_DLY (BDLY),
        .CONV_CYC (CCYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ad_reset    (ad_reset),
        .ad_convstab (ad_convstab),
        .ad_cs       (ad_cs),
        .ad_rd       (ad_rd),
        .ch_in       (ch_in),
        .ad_os       (ad_os),
        .ad_data     (ad_data),
        .ad_busy     (ad_busy),
        .first_data  (first_data)
    );

    always @(negedge clk) begin
        if (ad_busy) begin
            run_len <= run_len + 1;
        end else if (run_len != 0) begin
            last_width <= run_len;
            pulses     <= pulses + 1;
            run_len    <= 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int n = 0; n < 8; n++) begin
            m_regs[n] = '0;
            m_hold[n] = '0;
        end
        m_ptr  = 0;
        m_idle = 1'b1;
        m_ramp = 0;
    endtask

    task automatic m_latch();
        for (int n = 0; n < 8; n++) begin
`ifdef AD7606_EMU_RAMP_EN
            m_hold[n] = DW'(16'(m_ramp + n * 4096));
`else
            m_hold[n] = ch_in[n*DW +: DW];
`endif
        end
        m_idle = 1'b0;
    endtask

    task automatic m_commit();
        for (int n = 0; n < 8; n++)
            m_regs[n] = m_hold[n];
        m_ptr  = 0;
        m_ramp = (m_ramp + 1) % 65536;
    endtask

    task automatic randomize_ch();
        for (int n = 0; n < 8; n++)
            ch_in[n*DW +: DW] = DW'($urandom);
    endtask

    // Pin rises just after a clock edge; it is seen at the next edge (t),
    // detected at t+1, and busy rises BUSY_DLY edges later.
    task automatic start_conv(input string tag);
        int lat;
        lat = 0;
        m_latch();
        ad_convstab = 1'b1;
        while (!ad_busy && lat < 50) begin
            tick(1);
            lat++;
        end
        chk({tag, "_busy_latency"}, lat, BDLY + 2);
        ad_convstab = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (ad_busy && n < 1000) begin
            tick(1);
            n++;
        end
        chk({tag, "_busy_fell"}, 32'(ad_busy), 32'd0);
        tick(1);
    endtask

    task automatic do_read(input string tag);
        logic [DW-1:0] exp_d;
        logic          exp_f;
        exp_d = m_regs[m_ptr];
        exp_f = (m_ptr == 0);
        ad_rd = 1'b0;
        tick(3);
        $display("read %s: data=0x%04h first=%0b busy=%0b expect data=0x%04h first=%0b",
                 tag, ad_data, first_data, ad_busy, exp_d, exp_f);
        chk({tag, "_data"}, 32'(ad_data), 32'(exp_d));
        chk({tag, "_first"}, 32'(first_data), 32'(exp_f));
        ad_rd = 1'b1;
        tick(3);
        if (!m_idle)
            m_ptr = (m_ptr + 1) % 8;
    endtask

    initial begin
        m_reset();
        tick(3);
        rst_n = 1'b1;
        tick(2);
        chk("reset_data", 32'(ad_data), 32'd0);
        chk("reset_busy", 32'(ad_busy), 32'd0);
        chk("reset_first", 32'(first_data), 32'd0);

        // Conversion 1: known channel pattern 0x0101..0x0808
        for (int n = 0; n < 8; n++)
            ch_in[n*DW +: DW] = DW'((n + 1) * 'h0101);
        ad_os = 3'd2;
        start_conv("conv1");
        wait_done("conv1");
        chk("conv1_width", last_width, CCYC);
        chk("conv1_pulses", pulses, 1);
        m_commit();

        // Eight reads plus one more to show the pointer wrap
        ad_cs = 1'b0;
        tick(3);
        for (int r = 0; r < 9; r++)
            do_read($sformatf("c1_rd%0d", r));
        ad_cs = 1'b1;
        tick(3);
        chk("cs_high_data", 32'(ad_data), 32'd0);
        chk("cs_high_first", 32'(first_data), 32'd0);

        // Conversion 2: random data, reads while busy, extra convst mid-conversion
        randomize_ch();
        start_conv("conv2");
        ad_cs = 1'b0;
        tick(3);
        for (int r = 0; r < 3; r++)
            do_read($sformatf("c2_busy_rd%0d", r));
        ad_cs = 1'b1;
        randomize_ch();
        ad_convstab = 1'b1;
        tick(3);
        ad_convstab = 1'b0;
        chk("conv2_busy_after_extra_edge", 32'(ad_busy), 32'd1);
        wait_done("conv2");
        chk("conv2_width", last_width, CCYC);
        m_commit();
        tick(20);
        chk("conv2_no_extra_pulse", pulses, 2);
        ad_cs = 1'b0;
        tick(3);
        for (int r = 0; r < 8; r++)
            do_read($sformatf("c2_rd%0d", r));
        ad_cs = 1'b1;
        tick(3);

        // Conversion 3: aborted by ad_reset at busy cycle 100
        randomize_ch();
        start_conv("conv3");
        tick(99);
        chk("conv3_busy_before_reset", 32'(ad_busy), 32'd1);
        ad_reset = 1'b1;
        tick(1);
        chk("conv3_busy_after_reset", 32'(ad_busy), 32'd0);
        ad_reset = 1'b0;
        m_reset();
        ad_cs = 1'b0;
        tick(3);
        for (int r = 0; r < 2; r++)
            do_read($sformatf("idle_rd%0d", r));
        ad_cs = 1'b1;
        tick(3);

        // Conversion 4: fresh start from IDLE
        randomize_ch();
        start_conv("conv4");
        wait_done("conv4");
        chk("conv4_width", last_width, CCYC);
        m_commit();
        ad_cs = 1'b0;
        tick(3);
        for (int r = 0; r < 8; r++)
            do_read($sformatf("c4_rd%0d", r));
        ad_cs = 1'b1;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
